// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S / left-justified stereo receiver.
package i2s_pkg;

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_t;

    localparam logic FMT_I2S = 1'b0;
    localparam logic FMT_LJ  = 1'b1;

endpackage

// File: rtl/basic_bits.sv
// Small reusable bit-level helpers. edge_detect gives a one-cycle registered
// strobe on each rising edge of an already-synchronous input.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            d_q    <= d_i;
            rise_q <= d_i & ~d_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/i2s_pin_sync.sv
// Brings the codec pins into the clk domain and derives the bit-clock
// rising-edge strobe (2 synchroniser stages plus the edge register).
module i2s_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic sck_p_o,
    output logic ws_s_o,
    output logic sd_s_o
);

    // bit order in both stages: {sck, ws, sd}
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= {sck_i, ws_i, sd_i};
            sync_q <= meta_q;
        end
    end

    edge_detect u_sck_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sync_q[2]),
        .rise_o (sck_p_o)
    );

    assign ws_s_o = sync_q[1];
    assign sd_s_o = sync_q[0];

endmodule

// File: rtl/i2s_rx_stream.sv
// Stereo I2S / left-justified receiver: assembles MSB-first slots into
// DATA_W-bit left/right words and offers whole frames on a valid/ready stream.
module i2s_rx_stream
    import i2s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ws,
    input  logic              sd,
    input  logic              fmt,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic [CNT_W-1:0]  slot_bits
);

    logic sck_p;
    logic ws_s;
    logic sd_s;

    i2s_pin_sync u_pin_sync (
        .clk     (clk),
        .rst     (rst),
        .sck_i   (sck),
        .ws_i    (ws),
        .sd_i    (sd),
        .sck_p_o (sck_p),
        .ws_s_o  (ws_s),
        .sd_s_o  (sd_s)
    );

    i2s_state_t        state_q, state_d;
    logic              ws_prev_q, ws_prev_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] out_left_q, out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  slot_bits_q, slot_bits_d;

    logic              ws_chg;
    logic              lj;
    logic              frame_done;
    logic              load;
    logic [DATA_W-1:0] shift_in, fin_word, start_word;
    logic [CNT_W-1:0]  cnt_in, fin_cnt, start_cnt;

    // Bit n of a slot lands at DATA_W-1-n; bits beyond the word are dropped.
    function automatic logic [DATA_W-1:0] place_bit(input logic [DATA_W-1:0] word,
                                                    input logic [CNT_W-1:0]  n,
                                                    input logic              b);
        logic [DATA_W-1:0] r;
        r = word;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(n) == DATA_W - 1 - i) r[i] = b;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] n);
        return (n == '1) ? n : n + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        ws_prev_d  = ws_prev_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        frame_done = 1'b0;

        ws_chg   = sck_p && (ws_s != ws_prev_q);
        lj       = (fmt == FMT_LJ);
        shift_in = place_bit(shift_q, cnt_q, sd_s);
        cnt_in   = bump(cnt_q);
        // In I2S the bit on the ws edge still belongs to the slot that is
        // ending; in LJ it is already the MSB of the slot that is starting.
        fin_word   = lj ? shift_q : shift_in;
        fin_cnt    = lj ? cnt_q : cnt_in;
        start_word = lj ? place_bit('0, '0, sd_s) : '0;
        start_cnt  = lj ? CNT_W'(1) : '0;

        if (sck_p) begin
            ws_prev_d = ws_s;
            if (ws_chg) begin
                case (state_q)
                    SYNC: begin
                        if (!ws_s) begin
                            state_d = LEFT;
                            shift_d = start_word;
                            cnt_d   = start_cnt;
                        end
                    end
                    LEFT: begin
                        state_d = RIGHT;
                        left_d  = fin_word;
                        shift_d = start_word;
                        cnt_d   = start_cnt;
                    end
                    RIGHT: begin
                        state_d    = LEFT;
                        frame_done = 1'b1;
                        shift_d    = start_word;
                        cnt_d      = start_cnt;
                    end
                    default: state_d = SYNC;
                endcase
            end else if (state_q != SYNC) begin
                shift_d = shift_in;
                cnt_d   = cnt_in;
            end
        end
    end

    // Stream handshake: a frame transfers in any cycle where out_valid and
    // out_ready are both high; while out_valid is high the data is held stable.
    // A completion in the accepting cycle reloads the holder without a bubble.
    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        slot_bits_d = slot_bits_q;

        load = frame_done && (!out_valid_q || out_ready);

        if (load) begin
            out_left_d  = left_q;
            out_right_d = fin_word;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (frame_done) slot_bits_d = fin_cnt;
        if (frame_done && !load) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            ws_prev_q   <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            left_q      <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            slot_bits_q <= '0;
        end else begin
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            slot_bits_q <= slot_bits_d;
        end
    end

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign slot_bits = slot_bits_q;

endmodule

// File: doc/i2s_rx_stream.md
# i2s_rx_stream

Parametrised I2S / left-justified stereo receiver. It oversamples an external bit clock, word select and serial data in the system `clk` domain, and assembles MSB-first slots of any length into `DATA_W`-bit left/right words. Completed frames are delivered on a valid/ready stream with overrun detection. It sits between the codec pins and the audio sample pipeline, and replaces the fixed 16-bit decoder.

## Interface
- `DATA_W`, 16: output word width; 8..32.
- `CNT_W`, 6: slot bit-counter width; slots of up to 2^CNT_W-1 bits are handled.
- `clk` input 1: system clock; must be at least 4× the sck frequency.
- `rst` input 1: reset, asynchronous, active-high.
- `sck` input 1: I2S bit clock, asynchronous to `clk`.
- `ws` input 1: word select; 0 = left slot, 1 = right slot.
- `sd` input 1: serial data, MSB first.
- `fmt` input 1: 0 = I2S (1-bit delay after ws edge), 1 = left-justified. Quasi-static.
- `out_left` output DATA_W: left sample of the delivered frame.
- `out_right` output DATA_W: right sample of the delivered frame.
- `out_valid` output 1: frame available.
- `out_ready` input 1: consumer accepts the frame when `out_valid & out_ready`.
- `overrun` output 1: sticky; a frame was dropped. Cleared only by reset.
- `slot_bits` output CNT_W: bit count of the last completed right slot, for diagnostics.

## Operation
- `sck`, `ws` and `sd` each pass through a 2-FF synchroniser. A rising-edge strobe `sck_p` is derived from synchronised `sck`.
- On each `sck_p`: sample `ws_s` and `sd_s`. `ws_chg` = `ws_s` differs from the previously sampled ws.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC: ignore data. On a `ws_chg` to 0, go to LEFT and start a slot.
  - LEFT: on `ws_chg`, go to RIGHT.
  - RIGHT: on `ws_chg`, go to LEFT and complete the frame.
  - The first frame after reset is therefore always discarded.
- Slot start clears the slot shift register and bit counter.
- Bit placement:
  - Bit n of a slot (n = 0 is MSB) is written to index DATA_W-1-n while n < DATA_W.
  - Bits with n ≥ DATA_W are dropped (truncation).
  - Short slots leave the low bits zero (MSB-aligned, zero-padded).
  - The counter saturates at 2^CNT_W-1.
- fmt=1 (left-justified): the bit sampled on the `sck_p` that detects `ws_chg` is bit 0 of the new slot.
- fmt=0 (I2S): the bit sampled on the `ws_chg` edge is the final bit of the previous slot. Bit 0 of the new slot is the next `sck_p`.
- Frame complete: the left word and finished right word are copied to an output holding register, and `slot_bits` is updated.
  - If the holding register is free, or is being accepted in the same cycle, the copy succeeds and `out_valid` is 1 next cycle.
  - Otherwise the new frame is dropped, the held frame is kept, and `overrun` is set.
- Changing `fmt` outside SYNC is undefined. After changing it, software must reset.

## Timing
- Reset values: `out_left` = 0, `out_right` = 0, `out_valid` = 0, `overrun` = 0, `slot_bits` = 0, FSM in SYNC, shift registers and counters 0.
- Input-to-strobe latency is 3 `clk`: 2 synchroniser stages plus the edge register.
- `sck` high and low phases must each last at least 2 `clk`.
- `out_valid` rises 1 `clk` after the `sck_p` that completes the frame.
- `out_valid` stays high with stable data until `out_ready` is sampled high, then falls the next cycle unless a new frame loads in that same cycle.
- A frame completion coincident with acceptance loads with no bubble and does not set `overrun`.
- Asserting `rst` mid-frame clears everything immediately. After release, the block resynchronises in SYNC.

## Structure
- Package `i2s_pkg`:
  - `typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_t`.
  - `localparam FMT_I2S = 1'b0`, `FMT_LJ = 1'b1`.
- Sub-module `i2s_pin_sync` holds the 3-input 2-FF synchroniser plus the `sck` rising-edge strobe. It reuses `edge_detect` from `basic_bits.sv`.
- The FSM, slot assembly and output holding register stay in `i2s_rx_stream`.

## Test plan
- I2S, DATA_W=16, 32-bit slots, left = 0xA5A5_xxxx, right = 0x3C3C_xxxx → after the discarded first frame, every frame gives `out_left` = 0xA5A5 and `out_right` = 0x3C3C.
- fmt=1 (LJ), 16-bit slots, left = 0x8001, right = 0x7FFE → `out_left` = 0x8001, `out_right` = 0x7FFE, `slot_bits` = 16.
- DATA_W=24, 16-bit slots, left = 0x1234 → `out_left` = 0x123400 (zero-padded). With 32-bit slots, `slot_bits` = 32 and the low 8 bits are truncated.
- Hold `out_ready` = 0 across two completed frames → first frame held unchanged, `overrun` = 1. Raise `out_ready` on the exact completion cycle of a later frame → no overrun increment and new data is presented the next cycle.
- Assert `rst` mid left slot → all outputs 0 within the same cycle. The next full frame after release is delivered correctly; the partial frame is never output.
- Start the stream with `ws` = 1 → no output until the first 1→0 ws transition plus one complete frame.
